// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read-side controller: default word width,
// controller state encodings, pop counter width and the pop admission rule.
package fifo_pkg;

    localparam int FIFO_DATA_W = 10;
    localparam int POP_CNT_W   = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_STALL  = 2'd2
    } ctrl_state_t;

    // A pop is allowed only if the word it brings back will find a free skid
    // slot, counting words already buffered, the one in flight, and the one
    // leaving this cycle.
    function automatic logic can_pop(input logic [1:0] occ,
                                     input logic       inflight,
                                     input logic       leave);
        logic [2:0] pending;
        pending = {1'b0, occ} + {2'b00, inflight} - {2'b00, leave};
        return pending < 3'd2;
    endfunction

endpackage

// File: rtl/fifo_pop_ctrl_skid.sv
// Two-entry skid buffer that absorbs the upstream FIFO read latency.
// Storage is not reset; only pointers and occupancy are.
module pop_skid_buf
    import fifo_pkg::*;
#(
    parameter int DATA_W = FIFO_DATA_W
)(
    input  logic              clk,
    input  logic              reset_L,
    input  logic              wr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd,
    output logic [DATA_W-1:0] head,
    output logic [1:0]        occ
);

    logic [DATA_W-1:0] mem [2];
    logic              wr_ptr;
    logic              rd_ptr;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= 2'd0;
        end else begin
            if (wr) wr_ptr <= ~wr_ptr;
            if (rd) rd_ptr <= ~rd_ptr;
            occ <= occ + {1'b0, wr} - {1'b0, rd};
        end
    end

    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr] <= wr_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fifo_pop_ctrl.sv
// Read-side FIFO controller: pops upstream, buffers in a 2-entry skid and
// forwards with push/alm_full. Define FIFO_POP_CNT_EN to add pop_count.
module fifo_pop_ctrl
    import fifo_pkg::*;
#(
    parameter int DATA_W = FIFO_DATA_W
)(
    input  logic                 clk,
    input  logic                 reset_L,
    input  logic                 empty,
    input  logic [DATA_W-1:0]    fifo_data,
    input  logic                 ds_alm_full,
    output logic                 pop,
    output logic                 push_out,
    output logic [DATA_W-1:0]    data_out,
    output logic                 idle,
    output logic [1:0]           ctrl_state
`ifdef FIFO_POP_CNT_EN
    ,
    output logic [POP_CNT_W-1:0] pop_count
`endif
);

    logic [1:0]        occ;
    logic              inflight;
    logic              leave;
    logic [DATA_W-1:0] head;
    ctrl_state_t       state;
    ctrl_state_t       state_nxt;

    assign leave    = (occ != 2'd0) && !ds_alm_full;
    assign push_out = leave;
    // Gating with reset_L keeps pop low for the whole reset pulse.
    assign pop      = reset_L && !empty && can_pop(occ, inflight, leave);
    // With nothing buffered the head register is stale; present zero instead.
    assign data_out = (occ != 2'd0) ? head : '0;

    pop_skid_buf #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk     (clk),
        .reset_L (reset_L),
        .wr      (inflight),
        .wr_data (fifo_data),
        .rd      (leave),
        .head    (head),
        .occ     (occ)
    );

    // Read-latency stage: a pop issued now returns data next cycle.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) inflight <= 1'b0;
        else          inflight <= pop;
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (pop) state_nxt = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (ds_alm_full && (occ != 2'd0))
                    state_nxt = ST_STALL;
                else if ((occ == 2'd0) && !inflight && !pop && empty)
                    state_nxt = ST_IDLE;
            end
            ST_STALL: begin
                if (!ds_alm_full) state_nxt = ST_ACTIVE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign idle       = (state == ST_IDLE);
    assign ctrl_state = state;

`ifdef FIFO_POP_CNT_EN
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L)  pop_count <= '0;
        else if (pop)  pop_count <= pop_count + POP_CNT_W'(1);
    end
`endif

endmodule

// File: tb/tb_fifo_pop_ctrl.sv
// Directed bench for fifo_pop_ctrl: per-cycle vector table plus hand-written
// reset-mid-transfer and long-stream sequences.
module tb_fifo_pop_ctrl;

    logic       clk = 1'b0;
    logic       reset_L = 1'b0;
    logic       empty = 1'b1;
    logic [9:0] fifo_data = 10'h000;
    logic       ds_alm_full = 1'b0;
    logic       pop;
    logic       push_out;
    logic [9:0] data_out;
    logic       idle;
    logic [1:0] ctrl_state;
`ifdef FIFO_POP_CNT_EN
    logic [7:0] pop_count;
`endif

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fifo_pop_ctrl #(.DATA_W(10)) dut (
        .clk         (clk),
        .reset_L     (reset_L),
        .empty       (empty),
        .fifo_data   (fifo_data),
        .ds_alm_full (ds_alm_full),
        .pop         (pop),
        .push_out    (push_out),
        .data_out    (data_out),
        .idle        (idle),
        .ctrl_state  (ctrl_state)
`ifdef FIFO_POP_CNT_EN
        ,
        .pop_count   (pop_count)
`endif
    );

    typedef struct {
        logic       e;
        logic [9:0] fd;
        logic       af;
        logic       pop;
        logic       push;
        logic       dchk;
        logic [9:0] dout;
        logic [1:0] st;
    } vec_t;

    vec_t tbl[$];

    task automatic addv(input logic e, input logic [9:0] fd, input logic af,
                        input logic p, input logic pu, input logic dchk,
                        input logic [9:0] dout, input logic [1:0] st);
        vec_t v;
        v = '{e: e, fd: fd, af: af, pop: p, push: pu, dchk: dchk, dout: dout, st: st};
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    initial begin
        int popped;
        int pushed;
        logic prev_pop;

        // reset state, FIFO empty (rows 0..9)
        for (int i = 0; i < 10; i++) addv(1, 10'h000, 0, 0, 0, 1, 10'h000, 2'd0);
        // five words 0x001..0x005, no backpressure (rows 10..18)
        addv(0, 10'h000, 0, 1, 0, 0, 10'h000, 2'd0);
        addv(0, 10'h001, 0, 1, 0, 0, 10'h000, 2'd1);
        addv(0, 10'h002, 0, 1, 1, 1, 10'h001, 2'd1);
        addv(0, 10'h003, 0, 1, 1, 1, 10'h002, 2'd1);
        addv(0, 10'h004, 0, 1, 1, 1, 10'h003, 2'd1);
        addv(1, 10'h005, 0, 0, 1, 1, 10'h004, 2'd1);
        addv(1, 10'h2AA, 0, 0, 1, 1, 10'h005, 2'd1);
        addv(1, 10'h000, 0, 0, 0, 0, 10'h000, 2'd1);
        addv(1, 10'h000, 0, 0, 0, 0, 10'h000, 2'd0);
        // stream with ds_alm_full high for 4 cycles (rows 19..31)
        addv(0, 10'h000, 0, 1, 0, 0, 10'h000, 2'd0);
        addv(0, 10'h010, 0, 1, 0, 0, 10'h000, 2'd1);
        addv(0, 10'h011, 0, 1, 1, 1, 10'h010, 2'd1);
        addv(0, 10'h012, 1, 0, 0, 1, 10'h011, 2'd1);
        addv(0, 10'h3AA, 1, 0, 0, 1, 10'h011, 2'd2);
        addv(0, 10'h3AA, 1, 0, 0, 1, 10'h011, 2'd2);
        addv(0, 10'h3AA, 1, 0, 0, 1, 10'h011, 2'd2);
        addv(0, 10'h3AA, 0, 1, 1, 1, 10'h011, 2'd2);
        addv(0, 10'h013, 0, 1, 1, 1, 10'h012, 2'd1);
        addv(1, 10'h014, 0, 0, 1, 1, 10'h013, 2'd1);
        addv(1, 10'h3AA, 0, 0, 1, 1, 10'h014, 2'd1);
        addv(1, 10'h000, 0, 0, 0, 0, 10'h000, 2'd1);
        addv(1, 10'h000, 0, 0, 0, 0, 10'h000, 2'd0);
        // empty toggling, data 0x3FF/0x000 alternating (rows 32..40)
        addv(0, 10'h000, 0, 1, 0, 0, 10'h000, 2'd0);
        addv(1, 10'h3FF, 0, 0, 0, 0, 10'h000, 2'd1);
        addv(0, 10'h0F0, 0, 1, 1, 1, 10'h3FF, 2'd1);
        addv(1, 10'h000, 0, 0, 0, 0, 10'h000, 2'd1);
        addv(0, 10'h0F0, 0, 1, 1, 1, 10'h000, 2'd1);
        addv(1, 10'h3FF, 0, 0, 0, 0, 10'h000, 2'd1);
        addv(1, 10'h0F0, 0, 0, 1, 1, 10'h3FF, 2'd1);
        addv(1, 10'h000, 0, 0, 0, 0, 10'h000, 2'd1);
        addv(1, 10'h000, 0, 0, 0, 0, 10'h000, 2'd0);

        repeat (2) @(negedge clk);
        reset_L = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            empty       = tbl[i].e;
            fifo_data   = tbl[i].fd;
            ds_alm_full = tbl[i].af;
            #1;
            check($sformatf("row%0d pop", i), pop, tbl[i].pop);
            check($sformatf("row%0d push_out", i), push_out, tbl[i].push);
            if (tbl[i].dchk) check($sformatf("row%0d data_out", i), data_out, tbl[i].dout);
            check($sformatf("row%0d ctrl_state", i), ctrl_state, tbl[i].st);
            check($sformatf("row%0d idle", i), idle, tbl[i].st == 2'd0);
`ifdef FIFO_POP_CNT_EN
            if (i == 18) check("pop_count_after_5", pop_count, 8'd5);
`endif
        end
`ifdef FIFO_POP_CNT_EN
        check("pop_count_after_table", pop_count, 8'd13);
`endif

        // fill skid to 2 under backpressure, then reset mid-cycle
        @(negedge clk); empty = 1'b0; ds_alm_full = 1'b1; fifo_data = 10'h000;
        #1 check("rst_seq pop0", pop, 1'b1);
        @(negedge clk); fifo_data = 10'h0AA;
        #1 check("rst_seq pop1", pop, 1'b1);
        @(negedge clk); fifo_data = 10'h0BB;
        #1 check("rst_seq full pop", pop, 1'b0);
        check("rst_seq full push", push_out, 1'b0);
        @(negedge clk); fifo_data = 10'h0CC; ds_alm_full = 1'b0;
        #1 check("rst_seq head", data_out, 10'h0AA);
        check("rst_seq head push", push_out, 1'b1);
        #1 reset_L = 1'b0;
        #1 check("rst async pop", pop, 1'b0);
        check("rst async push", push_out, 1'b0);
        check("rst async data", data_out, 10'h000);
        check("rst async idle", idle, 1'b1);
        check("rst async state", ctrl_state, 2'd0);
`ifdef FIFO_POP_CNT_EN
        check("rst async pop_count", pop_count, 8'd0);
`endif
        @(negedge clk);
        #1 check("rst held push", push_out, 1'b0);
        @(negedge clk); reset_L = 1'b1; empty = 1'b0; fifo_data = 10'h000;
        #1 check("post_rst pop", pop, 1'b1);
        check("post_rst push", push_out, 1'b0);
        @(negedge clk); empty = 1'b1; fifo_data = 10'h155;
        #1 check("post_rst no stale push", push_out, 1'b0);
        check("post_rst no pop", pop, 1'b0);
        @(negedge clk); fifo_data = 10'h3C3;
        #1 check("post_rst push 155", push_out, 1'b1);
        check("post_rst data 155", data_out, 10'h155);
        @(negedge clk);
        #1 check("post_rst drained", push_out, 1'b0);

        // long stream of 260 words: throughput, order and counter wrap
        @(negedge clk); reset_L = 1'b0; empty = 1'b1;
        @(negedge clk); reset_L = 1'b1;
        popped = 0;
        pushed = 0;
        prev_pop = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            empty       = (popped >= 260);
            fifo_data   = prev_pop ? 10'(popped) : 10'h000;
            ds_alm_full = 1'b0;
            #1;
            if (push_out) begin
                pushed++;
                check($sformatf("stream word %0d", pushed), data_out, 10'(pushed));
            end
            prev_pop = pop;
            if (pop) popped++;
            if (c == 259) check("stream throughput", popped, 260);
        end
        check("stream popped", popped, 260);
        check("stream pushed", pushed, 260);
        check("stream idle", idle, 1'b1);
`ifdef FIFO_POP_CNT_EN
        check("pop_count wrap", pop_count, 8'd4);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
